receiver_t2: RTL
================

# receiver_t2

Receive-side counterpart of `transmitter_t2`. Accepts 16-bit channel codewords on a one-cycle `read` strobe and decodes them as extended Hamming (16,11) SECDED. Single-bit errors are corrected and double-bit errors are flagged. Decoded words are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, ≥2.
- `CNT_W`, default 16: width of the error statistic counters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `read`  in  1  codeword strobe; `symb_in` is sampled on every edge where `read`=1.
- `symb_in`  in  16  received codeword.
- `out_ready`  in  1  consumer accepts the head word when `valid_out`=1.
- `data_out`  out  11  decoded data at the FIFO head.
- `valid_out`  out  1  FIFO non-empty.
- `err_corr`  out  1  head word had a single error, now corrected.
- `err_uncorr`  out  1  head word had an uncorrectable double error.
- `overflow`  out  1  sticky; at least one decoded word was dropped.
- `corr_cnt`  out  CNT_W  corrected-word count.
- `uncorr_cnt`  out  CNT_W  uncorrectable-word count.

## Operation
- **Codeword layout.** Bit i is Hamming position i.
  - Parity bits sit at positions 1, 2, 4, 8.
  - Data bits sit at positions 3, 5, 6, 7, 9–15, with `data[0]` at position 3 and ascending from there.
  - Bit 0 is overall parity, giving even parity over all 16 bits.
- **Stage 1** (registered on a `read` edge):
  - syndrome `s[3:0]` = XOR of the indices of all set bits 1..15;
  - `p` = XOR of all 16 bits;
  - the codeword is held alongside `s` and `p`.
- **Stage 2 classification:**
  - `s`=0, `p`=0: clean.
  - `p`=1: single error at position `s` (`s`=0 means bit 0). Invert that bit, set `err_corr`.
  - `s`≠0, `p`=0: double error. Data is extracted uncorrected and `err_uncorr` is set.
- **Stage 2 write.** The extracted data and both flags are written into the FIFO as one entry.
- **FIFO:**
  - Head entry drives `data_out`, `err_corr`, `err_uncorr`.
  - A pop occurs on `valid_out & out_ready`.
  - Push while full with no pop in the same cycle: the word is dropped and `overflow` is set. The FIFO contents are untouched.
  - Push and pop in the same cycle while full: both are legal, no drop.
  - Pop while empty is ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Counters** (only with `RX_ERR_COUNT_EN` defined):
  - Increment when a flagged word leaves stage 2, whether or not it is dropped.
  - Saturate at all-ones.
- **Back-to-back reads** (`read` high on consecutive edges) are fully supported, one codeword per cycle.
- **Reset** (`reset`=0 at an edge):
  - clears the stage-1 valid flag, FIFO pointers, `overflow` and counters;
  - in-flight words are discarded;
  - `valid_out`, `err_corr`, `err_uncorr`, `overflow`, `corr_cnt`, `uncorr_cnt` = 0; `data_out` = 0.

## Timing
- `read` sampled at edge N → stage-1 registered at N → FIFO write at N+1.
- With the FIFO empty, `valid_out`=1 and the data are visible after edge N+1 (2-edge latency).
- A pop at edge M exposes the next entry, or drops `valid_out`, after M.
- `overflow` rises after the edge of the dropped write.
- A counter update is visible after edge N+1.

## Configuration
- Macro `RX_ERR_COUNT_EN`.
- Defined: `corr_cnt` and `uncorr_cnt` are live saturating counters.
- Undefined: no counter logic is synthesised; both ports are tied to 0. Per-word flags and `overflow` are unaffected.

## Structure
- **Package `rx_pkg`:**
  - `CW_W`=16, `DATA_W`=11;
  - data-position constant list;
  - function `syndrome(cw)` and function `extract(cw)`;
  - typedef for a FIFO entry `{err_uncorr, err_corr, data[10:0]}`.
- **Sub-module `rx_fifo`:** parameterised FWFT FIFO with `full`/`empty`, holding 13-bit entries.
- The decoder pipeline, overflow logic and counters live in `receiver_t2`.

## Test plan
- Reset, then `read` with 16'h0000 → after 2 edges `valid_out`=1, `data_out`=11'h000, both flags 0.
- `read` 16'hFFFF, then 16'hFFFB (bit 2 flipped), then 16'hFFFE (bit 0 flipped), `out_ready`=1:
  - three words of 11'h7FF;
  - `err_corr` = 0, 1, 1;
  - `corr_cnt`=2 with the macro defined, 0 without it.
- `read` 16'hFFF9 (bits 1 and 2 flipped) → `data_out`=11'h7FF uncorrected, `err_uncorr`=1, `uncorr_cnt`=1.
- Hold `out_ready`=0 and issue 5 back-to-back reads with `FIFO_DEPTH`=4:
  - `overflow`=1 after the 5th write;
  - draining yields exactly the first 4 words, in order.
- FIFO full with `out_ready`=1 and `read` every cycle → no drop; `overflow` stays 0 and the stream stays in order.
- Assert `reset`=0 one cycle after a `read` → no word appears; all outputs are 0 after the reset edge.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and helpers for the SECDED (16,11) receive path.
package rx_pkg;

    localparam int unsigned CW_W   = 16;
    localparam int unsigned DATA_W = 11;

    // Codeword position of each data bit, data[0] first.
    localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef struct packed {
        logic              err_uncorr;
        logic              err_corr;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic logic [3:0] syndrome(input logic [CW_W-1:0] cw);
        logic [3:0] s;
        s = '0;
        for (int unsigned i = 1; i < CW_W; i++) begin
            if (cw[i]) s = s ^ 4'(i);
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            d[k] = cw[DATA_POS[k]];
        end
        return d;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through FIFO; head is forced to zero while empty.
module rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         wr_en;
    logic         rd_en;

    // Extra pointer MSB distinguishes full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/receiver_t2.sv
// SECDED (16,11) decoder with FWFT output FIFO.
// Optional saturating error counters are enabled by defining RX_ERR_COUNT_EN.
module receiver_t2
    import rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic [15:0]       symb_in,
    input  logic              out_ready,
    output logic [10:0]       data_out,
    output logic              valid_out,
    output logic              err_corr,
    output logic              err_uncorr,
    output logic              overflow,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);

    logic            s1_valid;
    logic [CW_W-1:0] s1_cw;
    logic [3:0]      s1_s;
    logic            s1_p;

    logic [CW_W-1:0] fixed_cw;
    fifo_entry_t     entry;
    fifo_entry_t     head;
    logic            full;
    logic            empty;
    logic            pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= read;
        end
    end

    always_ff @(posedge clk) begin
        if (read) begin
            s1_cw <= symb_in;
            s1_s  <= syndrome(symb_in);
            s1_p  <= ^symb_in;
        end
    end

    // Odd overall parity means one flip at position s (s=0 is the parity bit itself).
    always_comb begin
        fixed_cw = s1_cw;
        if (s1_p) fixed_cw[s1_s] = ~s1_cw[s1_s];
        entry.data       = extract(fixed_cw);
        entry.err_corr   = s1_p;
        entry.err_uncorr = ~s1_p & (s1_s != 4'd0);
    end

    assign pop = valid_out & out_ready;

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s1_valid),
        .pop   (pop),
        .din   (entry),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign valid_out  = ~empty;
    assign data_out   = head.data;
    assign err_corr   = head.err_corr;
    assign err_uncorr = head.err_uncorr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (s1_valid && full && !pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef RX_ERR_COUNT_EN
    logic [CNT_W-1:0] corr_q;
    logic [CNT_W-1:0] uncorr_q;

    // Counted at stage 2, so dropped words are still included.
    always_ff @(posedge clk) begin
        if (!reset) begin
            corr_q   <= '0;
            uncorr_q <= '0;
        end else if (s1_valid) begin
            if (entry.err_corr && corr_q != '1)     corr_q   <= corr_q + CNT_W'(1);
            if (entry.err_uncorr && uncorr_q != '1) uncorr_q <= uncorr_q + CNT_W'(1);
        end
    end

    assign corr_cnt   = corr_q;
    assign uncorr_cnt = uncorr_q;
`else
    assign corr_cnt   = '0;
    assign uncorr_cnt = '0;
`endif

endmodule
